// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO with extra pointer bit for full/empty.
module fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0] wptr, rptr;
  logic do_push, do_pop;
  always_comb begin
    level   = wptr - rptr;
    empty   = wptr == rptr;
    full    = wptr == {~rptr[ADDR_W], rptr[ADDR_W-1:0]};
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rptr[ADDR_W-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  // a push at full only happens alongside a pop, so it overwrites the slot being read out
  always_ff @(posedge clk) if (do_push && !reset) mem[wptr[ADDR_W-1:0]] <= push_data;
endmodule

// File: rtl/strobe_rx.sv
// strobe_rx: toggle-flag handshake receiver landing async words in a local FWFT FIFO.
module strobe_rx #(
  parameter int WIDTH = 8,
  parameter int DELAY = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_toggle,
  input  logic [WIDTH-1:0]       req_data,
  output logic                   ack_toggle,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  logic [DELAY:0] sync;
  logic req_event, pending, full, empty, pop, can_write, write;
  always_comb begin
    req_event = sync[DELAY] ^ sync[DELAY-1];
    out_valid = !empty;
    pop       = out_valid && out_ready;
    can_write = !full || pop;
    write     = can_write && (req_event || pending);
  end
  // no reset term: the level held through reset becomes the baseline
  always_ff @(posedge clk) sync <= {sync[DELAY-1:0], req_toggle};
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_toggle <= 1'b0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (write) ack_toggle <= ~ack_toggle;
      pending <= pending ? !can_write : req_event && !can_write;
      if (req_event && pending) overflow <= 1'b1;
    end
  end
  fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (write),
    .push_data (req_data),
    .pop       (pop),
    .head      (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );
endmodule

// File: tb/tb_strobe_rx.sv
// tb_strobe_rx: directed scenarios for the toggle-handshake receiver.
module tb_strobe_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_toggle = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic ack_toggle, out_valid, overflow;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] level;
  int vectors = 0;
  int miscompares = 0;
  int acks_seen = 0;
  bit mon_en = 1'b0;
  logic [7:0] rx_q[$];

  strobe_rx #(.WIDTH(8), .DELAY(2), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_toggle (req_toggle),
    .req_data   (req_data),
    .ack_toggle (ack_toggle),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && out_valid && out_ready) rx_q.push_back(out_data);

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc(4);
    reset = 1'b0;
  endtask

  task automatic flip(input logic [7:0] d);
    req_data = d;
    req_toggle = ~req_toggle;
  endtask

  // compliant source: present word, flip request, wait (bounded) for the ack flip
  task automatic send(input logic [7:0] d, output bit ok);
    logic a0;
    a0 = ack_toggle;
    flip(d);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_toggle !== a0) begin
        ok = 1'b1;
        acks_seen++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    vectors++;
    if ({ack_toggle, out_valid, level, overflow} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: got ack/valid/level/ovf=%b required 000000", {ack_toggle, out_valid, level, overflow});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    flip(8'hA5);
    cyc(2);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early_valid: got %b required 0", out_valid);
    end
    cyc(1);
    vectors++;
    if ({out_valid, ack_toggle, level} !== 5'b11001 || out_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_word: got valid=%b ack=%b level=%0d data=%h required 1 1 1 a5", out_valid, ack_toggle, level, out_data);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pop: got level=%0d valid=%b required 0 0", level, out_valid);
    end
  endtask

  task automatic test_burst();
    bit ok;
    int bad;
    bad = 0;
    rx_q.delete();
    acks_seen = 0;
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), ok);
      if (!ok) bad++;
    end
    cyc(4);
    mon_en = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (bad != 0 || acks_seen != 16) begin
      miscompares++;
      $display("FAIL burst_acks: got %0d acks (%0d timeouts) required 16 (0)", acks_seen, bad);
    end
    vectors++;
    if (rx_q.size() != 16) begin
      miscompares++;
      $display("FAIL burst_count: got %0d words required 16", rx_q.size());
    end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL burst_word%0d: got %h required %h", i, rx_q[i], 8'(i));
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_overflow: got %b required 0", overflow);
    end
  endtask

  task automatic fill4(input logic [7:0] base);
    bit ok;
    for (int i = 0; i < 4; i++) begin
      send(base + 8'(i), ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL fill_ack%0d: got no ack required ack", i);
      end
    end
  endtask

  task automatic test_full();
    logic a0;
    do_reset();
    fill4(8'h10);
    a0 = ack_toggle;
    flip(8'h14);
    cyc(6);
    vectors++;
    if (ack_toggle !== a0 || level !== 3'd4) begin
      miscompares++;
      $display("FAIL full_withheld: got ack=%b level=%0d required ack=%b level=4", ack_toggle, level, a0);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    vectors++;
    if (ack_toggle !== ~a0 || level !== 3'd4 || out_data !== 8'h11) begin
      miscompares++;
      $display("FAIL full_pop_ack: got ack=%b level=%0d head=%h required ack=%b level=4 head=11", ack_toggle, level, out_data, ~a0);
    end
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL full_drain%0d: got valid=%b data=%h required 1 %h", i, out_valid, out_data, 8'h10 + 8'(i));
      end
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
    end
    vectors++;
    if (level !== 3'd0) begin
      miscompares++;
      $display("FAIL full_empty: got level=%0d required 0", level);
    end
  endtask

  task automatic test_violation();
    logic a0;
    do_reset();
    fill4(8'h20);
    a0 = ack_toggle;
    flip(8'h24);
    cyc(5);
    flip(8'h25);
    cyc(5);
    vectors++;
    if (overflow !== 1'b1 || level !== 3'd4 || ack_toggle !== a0) begin
      miscompares++;
      $display("FAIL viol_flag: got ovf=%b level=%0d ack=%b required 1 4 %b", overflow, level, ack_toggle, a0);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    vectors++;
    if (level !== 3'd4 || ack_toggle !== ~a0) begin
      miscompares++;
      $display("FAIL viol_pending_write: got level=%0d ack=%b required 4 %b", level, ack_toggle, ~a0);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(5);
    vectors++;
    if (level !== 3'd3 || ack_toggle !== ~a0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL viol_single_pending: got level=%0d ack=%b ovf=%b required 3 %b 1", level, ack_toggle, overflow, ~a0);
    end
  endtask

  task automatic test_mid_reset();
    vectors++;
    if (level !== 3'd3 || ack_toggle !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got level=%0d ack=%b required 3 1", level, ack_toggle);
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    vectors++;
    if ({level, out_valid, overflow, ack_toggle} !== 6'b0) begin
      miscompares++;
      $display("FAIL midrst_state: got level/valid/ovf/ack=%b required 000000", {level, out_valid, overflow, ack_toggle});
    end
  endtask

  task automatic test_reset_baseline();
    bit ok;
    @(negedge clk);
    reset = 1'b1;
    req_toggle = 1'b0;
    cyc(3);
    req_toggle = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(6);
    vectors++;
    if (out_valid !== 1'b0 || ack_toggle !== 1'b0 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL baseline: got valid=%b ack=%b level=%0d required 0 0 0", out_valid, ack_toggle, level);
    end
    send(8'h5A, ok);
    vectors++;
    if (!ok || out_data !== 8'h5A || level !== 3'd1) begin
      miscompares++;
      $display("FAIL baseline_next: got ack_ok=%b data=%h level=%0d required 1 5a 1", ok, out_data, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_violation();
    test_mid_reset();
    test_reset_baseline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
